// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aes_pkg
//  Purpose  : Shared types and constants for the AES front-end sequencer.
//             Provides the cipher mode encodings, the sequencer state enum,
//             and the packed job record latched on request acceptance.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

   localparam logic MODE_ENC = 1'b0;
   localparam logic MODE_DEC = 1'b1;

   // Widest job tag the job record can carry; narrower tags are zero-extended.
   localparam int AES_TAG_MAX_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      BUSY = 2'd2,
      RESP = 2'd3
   } seq_state_t;

   typedef struct packed {
      logic                     mode;
      logic [127:0]             key;
      logic [127:0]             text;
      logic [AES_TAG_MAX_W-1:0] tag;
   } aes_job_t;

endpackage
`default_nettype wire

// File: rtl/aes_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : aes_job_sequencer
//  Purpose  : Accepts one AES job per valid/ready handshake, drives the core
//             load/mode/key/text inputs, captures text_out on done and
//             returns it on a valid/ready response channel. A watchdog turns
//             a missing done into an error response.
//  Ports    : clk, rst                       - clock, sync active-high reset
//             req_valid/req_ready/req_*      - job request channel
//             aes_ld/aes_mode/aes_key/
//             aes_text_in/aes_text_out/
//             aes_done                       - AES core connection
//             rsp_valid/rsp_ready/rsp_*      - result channel
//             stray_done                     - sticky: done seen outside BUSY
//  Revision : 1.0 - initial release
// ============================================================================
module aes_job_sequencer
   import aes_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,   // >= 2
   parameter int TAG_W          = 4     // <= AES_TAG_MAX_W
) (
   input  logic               clk,
   input  logic               rst,

   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_mode,
   input  logic [127:0]       req_key,
   input  logic [127:0]       req_text,
   input  logic [TAG_W-1:0]   req_tag,

   output logic               aes_ld,
   output logic               aes_mode,
   output logic [127:0]       aes_key,
   output logic [127:0]       aes_text_in,
   input  logic [127:0]       aes_text_out,
   input  logic               aes_done,

   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [127:0]       rsp_text,
   output logic [TAG_W-1:0]   rsp_tag,
   output logic               rsp_err,

   output logic               stray_done
);

   localparam int                C_CNT_W     = $clog2(TIMEOUT_CYCLES);
   localparam logic [C_CNT_W-1:0] C_CNT_LIMIT = C_CNT_W'(TIMEOUT_CYCLES - 1);

   seq_state_t          r_state;
   aes_job_t            r_job;
   logic [127:0]        r_rsp_text;
   logic                r_rsp_err;
   logic [C_CNT_W-1:0]  r_cnt;
   logic                r_stray_done;

   // Handshake/strobe outputs are pure state decodes so they never depend
   // combinationally on any input.
   assign req_ready   = (r_state == IDLE);
   assign aes_ld      = (r_state == LOAD);
   assign rsp_valid   = (r_state == RESP);

   // Core inputs follow the job register, which only changes on acceptance,
   // so they are stable from LOAD through RESP.
   assign aes_mode    = r_job.mode;
   assign aes_key     = r_job.key;
   assign aes_text_in = r_job.text;

   assign rsp_text    = r_rsp_text;
   assign rsp_tag     = r_job.tag[TAG_W-1:0];
   assign rsp_err     = r_rsp_err;
   assign stray_done  = r_stray_done;

   // Tag bits above TAG_W are always zero; fold them into a sink.
   logic w_unused_tag_bits;
   assign w_unused_tag_bits = ^r_job.tag;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_job        <= '0;
         r_rsp_text   <= '0;
         r_rsp_err    <= 1'b0;
         r_cnt        <= '0;
         r_stray_done <= 1'b0;
      end else begin
         // A done outside BUSY belongs to no live job (e.g. a job dropped by
         // reset); flag it and keep it away from the result path.
         if (aes_done && (r_state != BUSY)) begin
            r_stray_done <= 1'b1;
         end

         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_job   <= '{mode: req_mode,
                               key:  req_key,
                               text: req_text,
                               tag:  AES_TAG_MAX_W'(req_tag)};
                  r_state <= LOAD;
               end
            end

            LOAD: begin
               r_cnt   <= '0;
               r_state <= BUSY;
            end

            BUSY: begin
               // done has priority over the watchdog limit in the same cycle.
               if (aes_done) begin
                  r_rsp_text <= aes_text_out;
                  r_rsp_err  <= 1'b0;
                  r_state    <= RESP;
               end else if (r_cnt == C_CNT_LIMIT) begin
                  r_rsp_text <= '0;
                  r_rsp_err  <= 1'b1;
                  r_state    <= RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            RESP: begin
               if (rsp_ready) begin
                  r_state <= IDLE;
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/aes_job_sequencer.md
# aes_job_sequencer

Front-end stage that sits directly upstream of `aes_top` and feeds it. It accepts one AES job per valid/ready handshake (mode, key, text, tag). It drives the core's load/mode/key/text inputs and holds them stable for the whole job. It captures the core's `text_out` on `done` and returns the result on a valid/ready response channel. A watchdog counter converts a missing `done` into an error response, so the system never hangs on a stuck core.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64, maximum number of BUSY cycles before the watchdog fires; legal range is ≥ 2.
- `TAG_W`, 4, width of the opaque job tag carried from request to response.

Ports:
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  job offered.
- `req_ready`  out  1  sequencer can accept a job.
- `req_mode`  in  1  0 = encrypt, 1 = decrypt.
- `req_key`  in  128  cipher key.
- `req_text`  in  128  plaintext or ciphertext.
- `req_tag`  in  TAG_W  job tag.
- `aes_ld`  out  1  one-cycle load strobe to the core's `ld`.
- `aes_mode`  out  1  to the core's `mode`.
- `aes_key`  out  128  to the core's `key`.
- `aes_text_in`  out  128  to the core's `text_in`.
- `aes_text_out`  in  128  from the core's `text_out`.
- `aes_done`  in  1  from the core's `done`.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_text`  out  128  result text; 0 on error.
- `rsp_tag`  out  TAG_W  tag of the completed job.
- `rsp_err`  out  1  1 = watchdog timeout.
- `stray_done`  out  1  sticky flag: `aes_done` was seen outside BUSY.

## Operation
- The FSM has four states: IDLE, LOAD, BUSY, RESP.
- **IDLE:**
  - `req_ready` = 1.
  - On `req_valid & req_ready`, latch mode/key/text/tag into the job registers and go to LOAD.
- **LOAD:**
  - `aes_ld` = 1 for exactly this cycle.
  - Clear the watchdog counter.
  - Go to BUSY.
- **BUSY:**
  - If `aes_done`: capture `aes_text_out` into `rsp_text`, set `rsp_err` = 0, go to RESP.
  - Else if the counter equals `TIMEOUT_CYCLES-1`: set `rsp_text` = 0 and `rsp_err` = 1, go to RESP.
  - Else increment the counter.
- **RESP:**
  - `rsp_valid` = 1; `rsp_text`/`rsp_tag`/`rsp_err` are stable.
  - On `rsp_ready`, go to IDLE.
- `aes_mode`, `aes_key` and `aes_text_in` are driven continuously from the job registers. They change only on request acceptance, so they are stable from LOAD through RESP.
- `req_ready` is 0 in LOAD, BUSY and RESP. There is one job in flight at a time and no queueing.
- `aes_done` seen in IDLE, LOAD or RESP is ignored for data and sets `stray_done`. The flag clears only on `rst`.
- If `aes_done` and the watchdog limit occur in the same cycle, `aes_done` wins (normal response, `rsp_err` = 0).
- The counter width is `$clog2(TIMEOUT_CYCLES)`. The counter never wraps; it stops at the limit.

## Timing
- **Reset values:**
  - state = IDLE
  - `req_ready` = 1 (it is a function of state)
  - `aes_ld` = 0, `aes_mode` = 0, `aes_key` = 0, `aes_text_in` = 0
  - `rsp_valid` = 0, `rsp_text` = 0, `rsp_tag` = 0, `rsp_err` = 0
  - `stray_done` = 0
  - counter = 0
- **Cycle sequence for one job:**
  - Request accepted at cycle N.
  - `aes_ld` is high in cycle N+1 (LOAD).
  - BUSY starts at cycle N+2.
  - `aes_done` sampled at cycle M → `rsp_valid` high from cycle M+1.
- The response handshake at cycle K returns the block to IDLE with `req_ready` = 1 at K+1. Back-to-back throughput is therefore core latency + 3 cycles.
- **Timeout:** BUSY lasts at most `TIMEOUT_CYCLES` cycles. Error `rsp_valid` rises at cycle N+2+`TIMEOUT_CYCLES`.
- All outputs except `req_ready`, `aes_ld` and `rsp_valid` come directly from registers. Those three are decoded from the state register only, never from inputs.
- **Reset mid-job:** `rst` in any state forces IDLE at the next edge. The in-flight job is dropped, with no response. A core `done` for the dropped job arriving after reset sets `stray_done`.

## Structure
- Shared package `aes_pkg`:
  - `MODE_ENC` = 1'b0 and `MODE_DEC` = 1'b1.
  - The `seq_state_t` enum {IDLE, LOAD, BUSY, RESP}.
  - A packed `aes_job_t` struct {mode, key, text, tag}.
- One module holds the FSM, the job register, the result register and the watchdog counter.
- No sub-module is needed. The block connects to `aes_top` at the system level and does not instantiate it.

## Test plan
- **Encrypt:** mode 0, key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff, tag 3, with `aes_top` attached → `rsp_text` = 69c4e0d86a7b0430d8cdb78070b4c55a, `rsp_tag` = 3, `rsp_err` = 0; `aes_ld` high for exactly one cycle, at N+1.
- **Decrypt:** mode 1, same key, text 69c4e0d86a7b0430d8cdb78070b4c55a → `rsp_text` = 00112233445566778899aabbccddeeff, `rsp_err` = 0.
- **Watchdog:** core model never asserts done, `TIMEOUT_CYCLES` = 8 → `rsp_valid` at N+10 with `rsp_err` = 1 and `rsp_text` = 0. With done forced on BUSY cycle 8 (the same cycle as the limit) → normal response, `rsp_err` = 0.
- **Backpressure:** `rsp_ready` held low for 20 cycles → `rsp_*` stable and `req_ready` = 0 throughout. A second `req_valid` is not accepted until the cycle after the response handshake.
- **Stray done / reset mid-job:** pulse `aes_done` in IDLE → `stray_done` = 1 and no `rsp_valid`. Assert `rst` during BUSY → IDLE next cycle, all outputs at reset values, no response emitted.
